// File: rtl/pmem_line_responder.sv
// Purpose : memory-side endpoint for the cache-line pmem handshake; serves whole-line reads/writes from an internal line array.
// Latency : request first visible in cycle 0 -> pmem_resp pulses in cycle LATENCY (1..255); array/rdata update on the edge entering RESP.
// Backpressure: none; requester holds pmem_read/pmem_write until pmem_resp, dropping both early aborts the operation.
// Ports   : clk, rst (async, active-high); pmem_read/pmem_write/pmem_address/pmem_wdata in;
//           pmem_rdata (line of last completed read), pmem_resp (1-cycle pulse), proto_err (sticky) out.
module pmem_line_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 256,
  parameter int INDEX_BITS = 5,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  pmem_resp,
  output logic                  proto_err
);

  localparam int OFS   = $clog2(LINE_BITS / 8);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [7:0] BUSY_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    cap_wr_q;
  logic [INDEX_BITS-1:0]   cap_idx_q;
  logic [LINE_BITS-1:0]    cap_wdata_q;
  logic [LINE_BITS-1:0]    mem_q [DEPTH];

  logic                    capture;
  logic                    access;
  logic                    perr_set;
  logic                    acc_wr;
  logic [INDEX_BITS-1:0]   acc_idx;
  logic [LINE_BITS-1:0]    acc_wdata;
  logic [INDEX_BITS-1:0]   req_idx;
  logic                    cap_req;
  logic                    other_req;

  // Upper address bits alias onto the same lines; offset bits select bytes within a line.
  assign req_idx = pmem_address[OFS+INDEX_BITS-1:OFS];

  logic unused_addr;
  assign unused_addr = ^{pmem_address[ADDR_WIDTH-1:OFS+INDEX_BITS], pmem_address[OFS-1:0]};

  assign cap_req   = cap_wr_q ? pmem_write : pmem_read;
  assign other_req = cap_wr_q ? pmem_read  : pmem_write;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    access    = 1'b0;
    perr_set  = 1'b0;
    acc_wr    = cap_wr_q;
    acc_idx   = cap_idx_q;
    acc_wdata = cap_wdata_q;
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          capture  = 1'b1;
          perr_set = pmem_read && pmem_write;
          if (LATENCY == 1) begin
            // No BUSY phase: the array access uses the live request directly.
            state_d   = RESP;
            access    = 1'b1;
            acc_wr    = pmem_write;
            acc_idx   = req_idx;
            acc_wdata = pmem_wdata;
          end else begin
            state_d = BUSY;
            cnt_d   = BUSY_LOAD;
          end
        end
      end
      BUSY: begin
        // A switch of request type is flagged but the captured operation continues;
        // only a fully withdrawn request aborts.
        if (other_req) perr_set = 1'b1;
        if (!cap_req && !other_req) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd1) begin
          state_d = RESP;
          cnt_d   = 8'd0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      cap_wr_q    <= 1'b0;
      cap_idx_q   <= '0;
      cap_wdata_q <= '0;
      proto_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        cap_wr_q    <= pmem_write;   // write wins when both are raised
        cap_idx_q   <= req_idx;
        cap_wdata_q <= pmem_wdata;
      end
      if (perr_set) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (access) begin
      if (acc_wr) mem_q[acc_idx] <= acc_wdata;
      else        pmem_rdata     <= mem_q[acc_idx];
    end
  end

  assign pmem_resp = (state_q == RESP);

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pmem_read = 1'b0, pmem_write = 1'b0;
  logic [31:0]  pmem_address = '0;
  logic [255:0] pmem_wdata = '0;
  logic [255:0] pmem_rdata;
  logic         pmem_resp, proto_err;

  logic         rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] wd1 = '0;
  logic [255:0] rdata1;
  logic         resp1, perr1;

  always #5 clk = ~clk;

  pmem_line_responder #(.ADDR_WIDTH(32), .LINE_BITS(256), .INDEX_BITS(5), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .proto_err(proto_err));

  pmem_line_responder #(.ADDR_WIDTH(32), .LINE_BITS(256), .INDEX_BITS(5), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_address(addr1), .pmem_wdata(wd1),
    .pmem_rdata(rdata1), .pmem_resp(resp1), .proto_err(perr1));

  int tests = 0;
  int fails = 0;

  // Reference model: a sparse line store keyed by line index, last read value, sticky error.
  logic [255:0] mem_m [int];
  logic [255:0] exp_rdata = '0;
  logic         perr_m = 1'b0;

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic [255:0] exp_rd;
  } vec_t;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % 32);
  endfunction

  function automatic logic [255:0] model_line(input int idx);
    return mem_m.exists(idx) ? mem_m[idx] : '0;
  endfunction

  function automatic vec_t mkv(input bit r, input bit w, input logic [31:0] a,
                               input logic [255:0] d, input logic [255:0] e);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wd = d; v.exp_rd = e;
    return v;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
  // hold = number of cycles after which the request is withdrawn (L means full transaction).
  task automatic do_txn(input bit r, input bit w, input logic [31:0] a, input logic [255:0] d,
                        input int hold, input string nm);
    int first = 0;
    int cnt = 0;
    logic [255:0] rd_at = 'x;
    bit complete;
    int idx;
    idx = line_of(a);
    complete = (hold >= L);
    pmem_read = r; pmem_write = w; pmem_address = a; pmem_wdata = d;
    for (int n = 1; n <= L + 1; n++) begin
      @(negedge clk);
      if (pmem_resp) begin
        cnt++;
        if (first == 0) first = n;
        rd_at = pmem_rdata;
      end
      if (n == hold) begin
        pmem_read = 1'b0; pmem_write = 1'b0;
      end
    end
    if (r && w) perr_m = 1'b1;
    check({nm, " resp_cycle"}, 256'(first), complete ? 256'(L) : 256'd0);
    check({nm, " resp_count"}, 256'(cnt), complete ? 256'd1 : 256'd0);
    if (complete) begin
      if (w) mem_m[idx] = d;
      else   exp_rdata = model_line(idx);
      check({nm, " rdata_at_resp"}, rd_at, exp_rdata);
    end
    check({nm, " rdata_after"}, pmem_rdata, exp_rdata);
    check({nm, " proto_err"}, 256'(proto_err), 256'(perr_m));
  endtask

  initial begin
    vec_t vecs[$];
    logic [255:0] pat;
    int rc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst resp", 256'(pmem_resp), 256'd0);
    check("rst rdata", pmem_rdata, 256'd0);
    check("rst perr", 256'(proto_err), 256'd0);
    check("rst resp1", 256'(resp1), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: write/read, aliasing and line independence
    vecs.push_back(mkv(1, 0, 32'h0000_0040, '0, '0));
    vecs.push_back(mkv(0, 1, 32'h0000_0060, {8{32'hDEADBEEF}}, '0));
    vecs.push_back(mkv(1, 0, 32'h0000_0060, '0, {8{32'hDEADBEEF}}));
    vecs.push_back(mkv(0, 1, 32'h0000_0060, {8{32'hAAAAAAAA}}, {8{32'hDEADBEEF}}));
    vecs.push_back(mkv(0, 1, 32'h0000_0080, {8{32'h55555555}}, {8{32'hDEADBEEF}}));
    vecs.push_back(mkv(1, 0, 32'h0000_0060, '0, {8{32'hAAAAAAAA}}));
    vecs.push_back(mkv(1, 0, 32'h0000_0080, '0, {8{32'h55555555}}));
    vecs.push_back(mkv(1, 0, 32'h0000_0460, '0, {8{32'hAAAAAAAA}}));
    foreach (vecs[i]) begin
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, L, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table_rdata", i), pmem_rdata, vecs[i].exp_rd);
    end

    // Abort: read withdrawn after 2 cycles, then a normal write and read-back
    do_txn(1, 0, 32'h0000_0080, '0, 2, "abort_rd");
    check("abort rdata_kept", pmem_rdata, {8{32'hAAAAAAAA}});
    do_txn(0, 1, 32'h0000_0100, {8{32'h0BADF00D}}, L, "post_abort_wr");
    do_txn(1, 0, 32'h0000_0100, '0, L, "post_abort_rd");

    // Protocol error: both requests raised -> served as a write, flag sticky
    check("perr before", 256'(proto_err), 256'd0);
    do_txn(1, 1, 32'h0000_00A0, {8{32'h13579BDF}}, L, "both_hi");
    repeat (10) @(negedge clk);
    check("perr sticky", 256'(proto_err), 256'd1);
    do_txn(1, 0, 32'h0000_00A0, '0, L, "both_hi_readback");

    // LATENCY=1 instance: response in cycle 1
    pat = {8{32'hC0FFEE01}};
    wr1 = 1'b1; addr1 = 32'h20; wd1 = pat;
    @(negedge clk);
    check("lat1 wr resp_c1", 256'(resp1), 256'd1);
    wr1 = 1'b0;
    @(negedge clk);
    check("lat1 wr resp_c2", 256'(resp1), 256'd0);
    rd1 = 1'b1;
    @(negedge clk);
    check("lat1 rd resp_c1", 256'(resp1), 256'd1);
    check("lat1 rd rdata", rdata1, pat);
    rd1 = 1'b0;
    @(negedge clk);
    check("lat1 rd resp_c2", 256'(resp1), 256'd0);

    // Reset in the middle of a write's BUSY phase
    pmem_write = 1'b1; pmem_address = 32'h60; pmem_wdata = {8{32'h12345678}};
    rc = 0;
    repeat (2) begin
      @(negedge clk);
      if (pmem_resp) rc++;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst resp", 256'(pmem_resp), 256'd0);
    check("midrst rdata", pmem_rdata, 256'd0);
    check("midrst perr", 256'(proto_err), 256'd0);
    pmem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_m.delete(); exp_rdata = '0; perr_m = 1'b0;
    repeat (L + 2) begin
      @(negedge clk);
      if (pmem_resp) rc++;
    end
    check("midrst no_resp", 256'(rc), 256'd0);
    do_txn(1, 0, 32'h0000_0060, '0, L, "midrst_readback");

    // Randomized traffic against the model, with occasional aborts
    for (int t = 0; t < 300; t++) begin
      bit w;
      int hold;
      logic [31:0] a;
      w    = $urandom_range(0, 1) == 1;
      a    = $urandom;
      hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, L - 1)) : L;
      do_txn(!w, w, a, rand_line(), hold, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Physical-memory-side responder for the cache-line pmem handshake used by the cache and victim-cache controllers (pmem_read / pmem_write / pmem_resp).
- Serves whole-line reads and writes from an internal line array with fixed, parameterised latency.
- Used as the memory endpoint under the cache hierarchy in simulation and as the bench target for controller verification.

Parameters:
ADDR_WIDTH, 32, byte address width.
LINE_BITS, 256, line width in bits; byte offset width OFS = log2(LINE_BITS/8) = 5.
INDEX_BITS, 5, line array depth = 2**INDEX_BITS lines.
LATENCY, 4, cycles from request-visible cycle to pmem_resp cycle; legal range 1 to 255.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-high.
pmem_read  input  1  line read request, held until pmem_resp is seen.
pmem_write  input  1  line write request, held until pmem_resp is seen.
pmem_address  input  ADDR_WIDTH  byte address, stable while request is high.
pmem_wdata  input  LINE_BITS  write line, stable while pmem_write is high.
pmem_rdata  output  LINE_BITS  read line, valid in the pmem_resp cycle of a read.
pmem_resp  output  1  single-cycle completion pulse.
proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset is asynchronous and active-high: the block enters IDLE immediately on rst. While in reset, pmem_resp=0, pmem_rdata=0 and proto_err=0, and the latency counter and all array lines are cleared to 0.
- Index is pmem_address[OFS+INDEX_BITS-1:OFS]. Upper address bits alias onto the same lines and are ignored.
- FSM states:
  - IDLE. If pmem_read xor pmem_write is high:
    - capture type, index and wdata at the edge;
    - go to BUSY if LATENCY>1, or to RESP if LATENCY==1.
    - If both are high: set proto_err, serve as a write (write priority).
  - BUSY. Lasts LATENCY-1 cycles, counted by an 8-bit down-counter.
    - If the captured request type drops to 0 during BUSY, abort to IDLE: no pmem_resp, no array update.
    - If the request switches type during BUSY, set proto_err and continue the originally captured operation.
  - RESP. Lasts exactly one cycle with pmem_resp=1, then go to IDLE unconditionally.
- Timing: request first visible in cycle 0 gives pmem_resp high in cycle LATENCY only.
- Array access, on the edge entering RESP:
  - write: array[index] <= captured wdata;
  - read: pmem_rdata <= array[index].
- pmem_rdata holds its last read value at all other times. Write transactions never change pmem_rdata.
- Read-after-write to the same index in consecutive transactions returns the new data.
- Request still high in the IDLE cycle after RESP is treated as a new transaction. Requesters are expected to drop the request in that cycle.
- proto_err stays high until rst.
- rst mid-transaction returns the block to IDLE without pmem_resp and discards the pending operation.

Test Plan:
- Reset: assert rst mid-cycle -> pmem_resp=0, pmem_rdata=0, proto_err=0 immediately. After release, a read of addr 0x40 returns 0.
- Write then read, LATENCY=4:
  - write addr 0x0000_0060, wdata {8{32'hDEADBEEF}}, held -> pmem_resp high only in cycle 4;
  - drop request, then read 0x60 -> pmem_resp in cycle 4 with rdata = that pattern.
- Aliasing / independence: write 0xAA..AA to index 3 (addr 0x60) and 0x55..55 to index 4 (addr 0x80). Reading 0x60, 0x80 and 0x460 returns AA, 55, AA respectively.
- Abort: read asserted for 2 cycles then dropped (LATENCY=4) -> no pmem_resp and pmem_rdata unchanged. The next write completes normally.
- Protocol error: pmem_read and pmem_write both high in IDLE -> proto_err=1, write performed, pmem_resp in cycle LATENCY, proto_err still 1 after 10 idle cycles.
- LATENCY=1 and rst mid-BUSY:
  - with LATENCY=1, pmem_resp is high in cycle 1;
  - with LATENCY=4, rst in cycle 2 of a write -> no pmem_resp, and a later read of that line returns 0.
